// File: rtl/sc_io_pkg.sv
// sc_io_pkg: shared switch-conditioner constants (switch width, default debounce length, one/two bit positions)
package sc_io_pkg;
  localparam int SC_SW_WIDTH = 8;
  localparam int SC_DEBOUNCE_DEFAULT = 50000;
  localparam int SC_SW_ONE_LSB = 0;
  localparam int SC_SW_TWO_LSB = 4;
endpackage

// File: rtl/sc_debounce_bit.sv
// sc_debounce_bit: 2-FF sync + debounce of one switch bit; ports clock, reset, raw -> stable, updated (combinational: stable flips at the next edge)
module sc_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic updated
);
  logic s1, s2, mis, done;
  logic [CNT_W-1:0] cnt;
  always_comb begin
    mis = s2 != stable;
    done = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
    updated = mis && done;
  end
  always_ff @(posedge clock)
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      stable <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      cnt <= (!mis || done) ? '0 : cnt + 1'b1;
      stable <= updated ? s2 : stable;
    end
endmodule

// File: rtl/sc_switch_conditioner.sv
// sc_switch_conditioner: sync+debounce sw_raw into sw_db/one/two, change_pulse + sticky change_flag (ack clears); change_cnt port only with SC_SWITCH_CHANGE_COUNT_EN
module sc_switch_conditioner
  import sc_io_pkg::*;
#(
  parameter int WIDTH = SC_SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = SC_DEBOUNCE_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             ack,
  output logic [3:0]       one,
  output logic [3:0]       two,
  output logic [WIDTH-1:0] sw_db,
  output logic             change_pulse,
  output logic             change_flag
`ifdef SC_SWITCH_CHANGE_COUNT_EN
  ,
  output logic [7:0]       change_cnt
`endif
);
  logic [WIDTH-1:0] upd;
  logic any_upd;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sc_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_bit (
      .clock(clock),
      .reset(reset),
      .raw(sw_raw[i]),
      .stable(sw_db[i]),
      .updated(upd[i])
    );
  end
  always_comb begin
    any_upd = |upd;
    one = sw_db[SC_SW_ONE_LSB +: 4];
    two = sw_db[SC_SW_TWO_LSB +: 4];
  end
  always_ff @(posedge clock)
    if (reset) begin
      change_pulse <= 1'b0;
      change_flag <= 1'b0;
`ifdef SC_SWITCH_CHANGE_COUNT_EN
      change_cnt <= '0;
`endif
    end else begin
      change_pulse <= any_upd;
      change_flag <= any_upd || (change_flag && !ack);
`ifdef SC_SWITCH_CHANGE_COUNT_EN
      change_cnt <= any_upd ? change_cnt + 8'd1 : change_cnt;
`endif
    end
endmodule

// File: tb/tb_sc_switch_conditioner.sv
// tb_sc_switch_conditioner: directed self-checking bench for sc_switch_conditioner with DEBOUNCE_CYCLES=4
module tb_sc_switch_conditioner;
  logic clock, reset, ack, change_pulse, change_flag;
  logic [7:0] sw_raw, sw_db;
  logic [3:0] one, two;
`ifdef SC_SWITCH_CHANGE_COUNT_EN
  logic [7:0] change_cnt;
`endif
  int checks = 0;
  int errors = 0;
  sc_switch_conditioner #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sw_raw(sw_raw),
    .ack(ack),
    .one(one),
    .two(two),
    .sw_db(sw_db),
    .change_pulse(change_pulse),
    .change_flag(change_flag)
`ifdef SC_SWITCH_CHANGE_COUNT_EN
    ,
    .change_cnt(change_cnt)
`endif
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    sw_raw = 8'h00;
    ack = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    sw_raw = 8'hFF;
    ack = 1'b0;
    repeat (3) tick();
    checks++;
    if (sw_db !== 8'h00 || change_pulse !== 1'b0 || change_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_state sw_db=%h pulse=%b flag=%b expected 00 0 0", sw_db, change_pulse, change_flag);
    end
    reset = 1'b0;
    repeat (5) tick();
    checks++;
    if (sw_db !== 8'h00 || change_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_early sw_db=%h pulse=%b expected 00 0", sw_db, change_pulse);
    end
    tick();
    checks++;
    if (sw_db !== 8'hFF || change_pulse !== 1'b1 || change_flag !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_update sw_db=%h pulse=%b flag=%b expected ff 1 1", sw_db, change_pulse, change_flag);
    end
    tick();
    checks++;
    if (sw_db !== 8'hFF || change_pulse !== 1'b0 || change_flag !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_after sw_db=%h pulse=%b flag=%b expected ff 0 1", sw_db, change_pulse, change_flag);
    end
  endtask
  task automatic test_operands;
    do_reset();
    sw_raw = 8'h35;
    repeat (5) tick();
    checks++;
    if (one !== 4'h0 || two !== 4'h0 || change_pulse !== 1'b0) begin
      errors++;
      $display("FAIL operands_early one=%h two=%h pulse=%b expected 0 0 0", one, two, change_pulse);
    end
    tick();
    checks++;
    if (one !== 4'h5 || two !== 4'h3 || sw_db !== 8'h35 || change_pulse !== 1'b1) begin
      errors++;
      $display("FAIL operands_update one=%h two=%h sw_db=%h pulse=%b expected 5 3 35 1", one, two, sw_db, change_pulse);
    end
    tick();
    checks++;
    if (change_pulse !== 1'b0 || sw_db !== 8'h35) begin
      errors++;
      $display("FAIL operands_pulse_width pulse=%b sw_db=%h expected 0 35", change_pulse, sw_db);
    end
  endtask
  task automatic test_glitch;
    int pulses;
    do_reset();
    pulses = 0;
    sw_raw = 8'h01;
    repeat (3) tick();
    sw_raw = 8'h00;
    repeat (10) begin
      tick();
      pulses += int'(change_pulse);
    end
    checks++;
    if (sw_db !== 8'h00 || pulses != 0) begin
      errors++;
      $display("FAIL glitch_short sw_db=%h pulses=%0d expected 00 0", sw_db, pulses);
    end
    do_reset();
    sw_raw = 8'h01;
    repeat (4) tick();
    sw_raw = 8'h00;
    tick();
    checks++;
    if (sw_db !== 8'h00) begin
      errors++;
      $display("FAIL glitch_wide_early sw_db=%h expected 00", sw_db);
    end
    tick();
    checks++;
    if (sw_db !== 8'h01 || change_pulse !== 1'b1) begin
      errors++;
      $display("FAIL glitch_wide_update sw_db=%h pulse=%b expected 01 1", sw_db, change_pulse);
    end
  endtask
  task automatic test_multi_bit;
    int pulses;
    do_reset();
    pulses = 0;
    sw_raw = 8'h81;
    repeat (5) tick();
    tick();
    checks++;
    if (sw_db !== 8'h81 || change_pulse !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_update sw_db=%h pulse=%b expected 81 1", sw_db, change_pulse);
    end
    pulses = int'(change_pulse);
    repeat (6) begin
      tick();
      pulses += int'(change_pulse);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL same_cycle_pulses got=%0d expected 1", pulses);
    end
    do_reset();
    sw_raw = 8'h01;
    tick();
    sw_raw = 8'h81;
    repeat (5) tick();
    checks++;
    if (sw_db !== 8'h01 || change_pulse !== 1'b1) begin
      errors++;
      $display("FAIL staggered_first sw_db=%h pulse=%b expected 01 1", sw_db, change_pulse);
    end
    tick();
    checks++;
    if (sw_db !== 8'h81 || change_pulse !== 1'b1) begin
      errors++;
      $display("FAIL staggered_second sw_db=%h pulse=%b expected 81 1", sw_db, change_pulse);
    end
    tick();
    checks++;
    if (change_pulse !== 1'b0) begin
      errors++;
      $display("FAIL staggered_end pulse=%b expected 0", change_pulse);
    end
  endtask
  task automatic test_ack;
    do_reset();
    sw_raw = 8'h01;
    repeat (5) tick();
    ack = 1'b1;
    tick();
    checks++;
    if (change_pulse !== 1'b1 || change_flag !== 1'b1) begin
      errors++;
      $display("FAIL ack_coincide pulse=%b flag=%b expected 1 1", change_pulse, change_flag);
    end
    tick();
    checks++;
    if (change_flag !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear flag=%b expected 0", change_flag);
    end
    ack = 1'b0;
    tick();
    checks++;
    if (change_flag !== 1'b0 || change_pulse !== 1'b0) begin
      errors++;
      $display("FAIL ack_stays_clear flag=%b pulse=%b expected 0 0", change_flag, change_pulse);
    end
  endtask
`ifdef SC_SWITCH_CHANGE_COUNT_EN
  task automatic test_change_count;
    do_reset();
    for (int n = 0; n < 256; n++) begin
      sw_raw = {7'h00, ~sw_raw[0]};
      repeat (8) tick();
      if (n == 254) begin
        checks++;
        if (change_cnt !== 8'd255) begin
          errors++;
          $display("FAIL count_255 got=%0d expected 255", change_cnt);
        end
      end
    end
    checks++;
    if (change_cnt !== 8'd0) begin
      errors++;
      $display("FAIL count_wrap got=%0d expected 0", change_cnt);
    end
    do_reset();
    repeat (2) begin
      sw_raw = {7'h00, ~sw_raw[0]};
      repeat (8) tick();
    end
    checks++;
    if (change_cnt !== 8'd2) begin
      errors++;
      $display("FAIL count_two got=%0d expected 2", change_cnt);
    end
    sw_raw = 8'h01;
    repeat (3) tick();
    reset = 1'b1;
    sw_raw = 8'h00;
    tick();
    checks++;
    if (change_cnt !== 8'd0 || sw_db !== 8'h00) begin
      errors++;
      $display("FAIL count_reset got=%0d sw_db=%h expected 0 00", change_cnt, sw_db);
    end
    reset = 1'b0;
    repeat (8) tick();
    checks++;
    if (change_cnt !== 8'd0 || sw_db !== 8'h00) begin
      errors++;
      $display("FAIL count_after_reset got=%0d sw_db=%h expected 0 00", change_cnt, sw_db);
    end
  endtask
`endif
  initial begin
    reset = 1'b1;
    sw_raw = 8'h00;
    ack = 1'b0;
    test_reset();
    test_operands();
    test_glitch();
    test_multi_bit();
    test_ack();
`ifdef SC_SWITCH_CHANGE_COUNT_EN
    test_change_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
